// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
//   Bundle of the fetch stage's control, memory and IF/ID signals.
//   The master modport is the fetch stage's view. The slave modport is the
//   view of the surrounding pipeline and memory.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface if_stage_if;
  // Hazard unit and EX-stage control
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  // Instruction memory
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  // IF/ID pipeline register
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        fetch_fault_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
    output imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
           if_id_valid_o, fetch_fault_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
    input  imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
           if_id_valid_o, fetch_fault_o
  );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. It owns the PC and drives the instruction memory
//   address. It latches the fetched word into IF/ID and handles stall, flush,
//   redirect and bad-PC fetch faults.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 131072
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_stage_if.master  bus
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 32'd4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic        bad_pc;
  logic        ifid_bubble;
  logic        ifid_load;

  assign pc_plus4 = pc_q + 32'd4;
  // An unaligned PC, or a PC whose word would run past the end of memory, cannot be fetched.
  assign bad_pc   = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);

  // Next-state, PC and IF/ID update selection; hold everything unless a case says otherwise.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // The PC is not advanced. The only way to move it here is a redirect.
        state_d = ST_RUN;
        if (bus.redirect_i) begin
          pc_d = bus.redirect_pc_i;
        end
        if (bus.redirect_i || bus.flush_i || !bus.stall_i) begin
          ifid_bubble = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.redirect_i) begin
          pc_d        = bus.redirect_pc_i;
          ifid_bubble = 1'b1;
        end else if (bus.stall_i) begin
          // The PC holds. Flush still wins over stall on the IF/ID side.
          ifid_bubble = bus.flush_i;
        end else if (bad_pc) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          ifid_bubble = 1'b1;
        end else begin
          pc_d = pc_plus4;
          if (bus.flush_i) begin
            ifid_bubble = 1'b1;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end

      ST_FAULT: begin
        // Only a redirect leaves FAULT. Stall and flush do not.
        ifid_bubble = 1'b1;
        if (bus.redirect_i) begin
          state_d = ST_RUN;
          pc_d    = bus.redirect_pc_i;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_BOOT;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  // IF/ID register contents for this edge. A bubble tags the current PC so that debug views stay readable.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (ifid_load) begin
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = bus.imem_data_i;
      ifid_valid_d = 1'b1;
    end else if (ifid_bubble) begin
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
    end
  end

  // State, PC, fault flag and IF/ID registers. Reset clears them without waiting for an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.imem_addr_o   = pc_q;
  assign bus.if_id_pc_o    = ifid_pc_q;
  assign bus.if_id_pc4_o   = ifid_pc4_q;
  assign bus.if_id_instr_o = ifid_instr_q;
  assign bus.if_id_valid_o = ifid_valid_q;
  assign bus.fetch_fault_o = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
//   Directed bench for if_stage. Memory returns 32'hC0DE_0000 | addr[15:0].
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (131072)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  assign bus.imem_data_i = 32'hC0DE_0000 | {16'h0000, bus.imem_addr_o[15:0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  bus.imem_addr_o, 32'h0);
    chk({tag, "_pc"},    bus.if_id_pc_o, 32'h0);
    chk({tag, "_pc4"},   bus.if_id_pc4_o, 32'h0);
    chk({tag, "_instr"}, bus.if_id_instr_o, 32'h0000_0013);
    chk({tag, "_valid"}, 32'(bus.if_id_valid_o), 32'h0);
    chk({tag, "_fault"}, 32'(bus.fetch_fault_o), 32'h0);
  endtask

  task automatic boot_seq(input string tag);
    tick();
    chk({tag, "_boot_valid"}, 32'(bus.if_id_valid_o), 32'h0);
    chk({tag, "_boot_addr"}, bus.imem_addr_o, 32'h0);
    tick();
    chk({tag, "_e2_pc"}, bus.if_id_pc_o, 32'h0);
    chk({tag, "_e2_pc4"}, bus.if_id_pc4_o, 32'h4);
    chk({tag, "_e2_instr"}, bus.if_id_instr_o, 32'hC0DE_0000);
    chk({tag, "_e2_valid"}, 32'(bus.if_id_valid_o), 32'h1);
    tick();
    chk({tag, "_e3_pc"}, bus.if_id_pc_o, 32'h4);
    chk({tag, "_e3_instr"}, bus.if_id_instr_o, 32'hC0DE_0004);
    tick();
    chk({tag, "_e4_pc"}, bus.if_id_pc_o, 32'h8);
    chk({tag, "_e4_instr"}, bus.if_id_instr_o, 32'hC0DE_0008);
    chk({tag, "_e4_valid"}, 32'(bus.if_id_valid_o), 32'h1);
    chk({tag, "_e4_addr"}, bus.imem_addr_o, 32'hC);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;

    // Test 1: reset values, then the boot sequence.
    #1;
    chk_reset_vals("rst0");
    @(posedge clk);
    #3 rst = 1'b0;
    boot_seq("t1");

    // Test 2: stall at pc 0x10.
    tick();
    chk("t2_pre_pc", bus.if_id_pc_o, 32'hC);
    chk("t2_pre_addr", bus.imem_addr_o, 32'h10);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_addr", bus.imem_addr_o, 32'h10);
      chk("t2_stall_pc", bus.if_id_pc_o, 32'hC);
      chk("t2_stall_instr", bus.if_id_instr_o, 32'hC0DE_000C);
      chk("t2_stall_valid", 32'(bus.if_id_valid_o), 32'h1);
    end
    bus.stall_i = 1'b0;
    tick();
    chk("t2_rel_pc10", bus.if_id_pc_o, 32'h10);
    chk("t2_rel_instr10", bus.if_id_instr_o, 32'hC0DE_0010);
    chk("t2_rel_valid", 32'(bus.if_id_valid_o), 32'h1);
    tick();
    chk("t2_rel_pc14", bus.if_id_pc_o, 32'h14);
    chk("t2_rel_addr18", bus.imem_addr_o, 32'h18);

    // A flush on its own makes a bubble, and the PC still advances.
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("fl_instr", bus.if_id_instr_o, 32'h0000_0013);
    chk("fl_addr", bus.imem_addr_o, 32'h1C);

    // Test 3: a redirect together with a stall. The redirect wins.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    bus.stall_i       = 1'b1;
    tick();
    bus.redirect_i = 1'b0;
    bus.stall_i    = 1'b0;
    chk("t3_bub_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("t3_bub_instr", bus.if_id_instr_o, 32'h0000_0013);
    chk("t3_addr", bus.imem_addr_o, 32'h100);
    tick();
    chk("t3_pc", bus.if_id_pc_o, 32'h100);
    chk("t3_instr", bus.if_id_instr_o, 32'hC0DE_0100);
    chk("t3_valid", 32'(bus.if_id_valid_o), 32'h1);

    // Test 4: a misaligned redirect leads to FAULT. Stall and flush cannot leave it.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h102;
    tick();
    bus.redirect_i = 1'b0;
    chk("t4_addr", bus.imem_addr_o, 32'h102);
    chk("t4_bub", 32'(bus.if_id_valid_o), 32'h0);
    tick();
    chk("t4_fault", 32'(bus.fetch_fault_o), 32'h1);
    chk("t4_fault_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("t4_fault_addr", bus.imem_addr_o, 32'h102);
    for (int i = 0; i < 4; i++) begin
      bus.flush_i = i[0];
      bus.stall_i = i[1];
      tick();
      chk("t4_hold_fault", 32'(bus.fetch_fault_o), 32'h1);
      chk("t4_hold_valid", 32'(bus.if_id_valid_o), 32'h0);
      chk("t4_hold_addr", bus.imem_addr_o, 32'h102);
    end
    bus.flush_i       = 1'b0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h200;
    tick();
    bus.redirect_i = 1'b0;
    chk("t4_clr_fault", 32'(bus.fetch_fault_o), 32'h0);
    chk("t4_clr_addr", bus.imem_addr_o, 32'h200);
    chk("t4_clr_valid", 32'(bus.if_id_valid_o), 32'h0);
    tick();
    chk("t4_pc200", bus.if_id_pc_o, 32'h200);
    chk("t4_instr200", bus.if_id_instr_o, 32'hC0DE_0200);
    chk("t4_valid200", 32'(bus.if_id_valid_o), 32'h1);

    // Test 5: the last word of memory is fetched, then the stage faults past the end.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0001_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    chk("t5_addr", bus.imem_addr_o, 32'h0001_FFFC);
    tick();
    chk("t5_last_pc", bus.if_id_pc_o, 32'h0001_FFFC);
    chk("t5_last_pc4", bus.if_id_pc4_o, 32'h0002_0000);
    chk("t5_last_instr", bus.if_id_instr_o, 32'hC0DE_FFFC);
    chk("t5_last_valid", 32'(bus.if_id_valid_o), 32'h1);
    chk("t5_end_addr", bus.imem_addr_o, 32'h0002_0000);
    chk("t5_nofault_yet", 32'(bus.fetch_fault_o), 32'h0);
    tick();
    chk("t5_fault", 32'(bus.fetch_fault_o), 32'h1);
    chk("t5_no_valid", 32'(bus.if_id_valid_o), 32'h0);
    chk("t5_addr_held", bus.imem_addr_o, 32'h0002_0000);
    tick();
    chk("t5_no_valid2", 32'(bus.if_id_valid_o), 32'h0);

    // Test 6: reset asserted between edges while IF/ID holds a valid instruction.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h40;
    tick();
    bus.redirect_i = 1'b0;
    tick();
    chk("t6_pre_valid", 32'(bus.if_id_valid_o), 32'h1);
    chk("t6_pre_pc", bus.if_id_pc_o, 32'h40);
    #3 rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    @(posedge clk);
    #3 rst = 1'b0;
    boot_seq("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
